// File: rtl/rx32_thread_pkg.sv
// Shared types and constants for the five-thread instruction fetch scheduler.
// Each thread owns a 100-word window of the 512-word instruction memory.
package rx32_thread_pkg;
  localparam int NUM_THREADS = 5;
  localparam int SLOT_DEPTH  = 100;
  localparam int ADDR_W      = 9;

  typedef logic [2:0]        tid_t;
  typedef logic [6:0]        pc_off_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t THREAD_BASE [NUM_THREADS] = '{9'd0, 9'd100, 9'd200, 9'd300, 9'd400};

  function automatic logic in_range(tid_t t, pc_off_t p, logic chk_pc);
    return (int'(t) < NUM_THREADS) && (!chk_pc || int'(p) < SLOT_DEPTH);
  endfunction

  function automatic pc_off_t pc_inc(pc_off_t p);
    return (p == pc_off_t'(SLOT_DEPTH-1)) ? '0 : p + 7'd1;
  endfunction

  function automatic addr_t base_addr(tid_t t);
    addr_t b;
    b = '0;
    for (int i = 0; i < NUM_THREADS; i++)
      if (t == tid_t'(i)) b = THREAD_BASE[i];
    return b;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Five-way round-robin pick: first eligible thread strictly after ptr,
// wrapping so that ptr itself is considered last.
module rr_arbiter
  import rx32_thread_pkg::*;
(
  input  logic [NUM_THREADS-1:0] elig,
  input  logic [2:0]             ptr,
  output logic [NUM_THREADS-1:0] gnt_oh,
  output logic [2:0]             gnt_id,
  output logic                   gnt_vld
);
  always_comb begin : arb
    int idx;
    idx     = 0;
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = (int'(ptr) + i) % NUM_THREADS;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld     = 1'b1;
        gnt_id      = tid_t'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/thread_fetch_scheduler.sv
// Round-robin instruction fetch scheduler for five hardware threads; presents
// one registered fetch beat per cycle with a valid/ready handshake.
module thread_fetch_scheduler
  import rx32_thread_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  input  logic [2:0]             start_tid,
  input  logic [6:0]             start_pc,
  input  logic                   halt_valid,
  input  logic [2:0]             halt_tid,
  input  logic                   redirect_valid,
  input  logic [2:0]             redirect_tid,
  input  logic [6:0]             redirect_pc,
  input  logic [NUM_THREADS-1:0] thread_stall,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [2:0]             fetch_tid,
  output logic [6:0]             fetch_pc,
  output logic [ADDR_W-1:0]      imem_a,
  output logic [NUM_THREADS-1:0] active,
  output logic                   cmd_err
);
  logic [NUM_THREADS-1:0]      active_q, active_d;
  logic [NUM_THREADS-1:0][6:0] pc_q, pc_d;
  tid_t                        rr_ptr_q, rr_ptr_d;
  logic                        fetch_valid_q, fetch_valid_d;
  tid_t                        fetch_tid_q, fetch_tid_d;
  pc_off_t                     fetch_pc_q, fetch_pc_d;
  logic                        cmd_err_q, cmd_err_d;

  logic                   start_ok, halt_ok, redir_ok;
  logic [NUM_THREADS-1:0] start_hit, halt_hit, redir_hit, pc_reload, fetch_oh;
  logic [NUM_THREADS-1:0] elig, gnt_oh;
  tid_t                   gnt_id;
  logic                   gnt_vld, flush, load;
  pc_off_t                gnt_pc;

  always_comb begin
    start_ok  = start_valid    && in_range(start_tid, start_pc, 1'b1);
    halt_ok   = halt_valid     && in_range(halt_tid, '0, 1'b0);
    redir_ok  = redirect_valid && in_range(redirect_tid, redirect_pc, 1'b1);
    cmd_err_d = (start_valid && !start_ok) || (halt_valid && !halt_ok) ||
                (redirect_valid && !redir_ok);
    start_hit = '0;
    halt_hit  = '0;
    redir_hit = '0;
    fetch_oh  = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      start_hit[t] = start_ok && (start_tid == tid_t'(t));
      halt_hit[t]  = halt_ok  && (halt_tid == tid_t'(t));
      redir_hit[t] = redir_ok && (redirect_tid == tid_t'(t));
      fetch_oh[t]  = (fetch_tid_q == tid_t'(t));
    end
    // A start on an already running thread behaves as a redirect.
    pc_reload = (redir_hit | start_hit) & active_q;
    elig      = active_q & ~thread_stall & ~(start_hit | halt_hit | redir_hit);
    flush     = fetch_valid_q && !fetch_ready && |(fetch_oh & (halt_hit | pc_reload));
    load      = !fetch_valid_q || fetch_ready || flush;
  end

  rr_arbiter u_arb (
    .elig    (elig),
    .ptr     (rr_ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    gnt_pc   = '0;
    active_d = active_q;
    pc_d     = pc_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (gnt_oh[t]) gnt_pc = gnt_pc | pc_q[t];
      if (halt_hit[t])
        active_d[t] = 1'b0;
      else if (redir_hit[t] && active_q[t])
        pc_d[t] = redirect_pc;
      else if (start_hit[t]) begin
        active_d[t] = 1'b1;
        pc_d[t]     = start_pc;
      end else if (load && gnt_oh[t])
        pc_d[t] = pc_inc(pc_q[t]);
    end
  end

  always_comb begin
    fetch_valid_d = fetch_valid_q;
    fetch_tid_d   = fetch_tid_q;
    fetch_pc_d    = fetch_pc_q;
    rr_ptr_d      = rr_ptr_q;
    if (load) begin
      fetch_valid_d = gnt_vld;
      if (gnt_vld) begin
        fetch_tid_d = gnt_id;
        fetch_pc_d  = gnt_pc;
        rr_ptr_d    = gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= '0;
      pc_q          <= '0;
      rr_ptr_q      <= tid_t'(NUM_THREADS-1);
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= '0;
      fetch_pc_q    <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      active_q      <= active_d;
      pc_q          <= pc_d;
      rr_ptr_q      <= rr_ptr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_tid_q   <= fetch_tid_d;
      fetch_pc_q    <= fetch_pc_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_tid   = fetch_tid_q;
  assign fetch_pc    = fetch_pc_q;
  assign imem_a      = base_addr(fetch_tid_q) + addr_t'(fetch_pc_q);
  assign active      = active_q;
  assign cmd_err     = cmd_err_q;
endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Scoreboard bench for thread_fetch_scheduler: directed stimulus pushes the
// hand-computed beat sequence; a monitor pops on every accepted beat.
module tb_thread_fetch_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, halt_valid, redirect_valid;
  logic [2:0] start_tid, halt_tid, redirect_tid;
  logic [6:0] start_pc, redirect_pc;
  logic [4:0] thread_stall;
  logic       fetch_ready;
  logic       fetch_valid;
  logic [2:0] fetch_tid;
  logic [6:0] fetch_pc;
  logic [8:0] imem_a;
  logic [4:0] active;
  logic       cmd_err;

  typedef struct { int tid; int pc; int addr; } beat_t;
  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  thread_fetch_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_tid(start_tid), .start_pc(start_pc),
    .halt_valid(halt_valid), .halt_tid(halt_tid),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .thread_stall(thread_stall), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_tid(fetch_tid), .fetch_pc(fetch_pc),
    .imem_a(imem_a), .active(active), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int tid, int pc, int addr);
    beat_t b;
    b.tid = tid; b.pc = pc; b.addr = addr;
    exp_q.push_back(b);
  endtask

  // Inputs change at negedge+3; the monitor samples at negedge+4.
  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  // Counts accepted beats starting with the current cycle.
  task automatic wait_beats(input int n, output int gaps);
    int cnt, cyc;
    cnt = 0; cyc = 0; gaps = 0;
    forever begin
      if (fetch_valid && fetch_ready) cnt++;
      else if (cnt > 0) gaps++;
      if (cnt == n || cyc == 400) break;
      tick();
      cyc++;
    end
    if (cnt != n) chk("beat_timeout", cnt, n);
  endtask

  always begin
    beat_t e;
    @(negedge clk);
    #4;
    if (rst_n && fetch_valid && fetch_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_addr", int'(imem_a), -1);
      end else begin
        e = exp_q.pop_front();
        chk("beat_tid", int'(fetch_tid), e.tid);
        chk("beat_pc", int'(fetch_pc), e.pc);
        chk("beat_addr", int'(imem_a), e.addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    rst_n = 1'b0;
    start_valid = 0; start_tid = 0; start_pc = 0;
    halt_valid = 0; halt_tid = 0;
    redirect_valid = 0; redirect_tid = 0; redirect_pc = 0;
    thread_stall = '0; fetch_ready = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", int'(fetch_valid), 0);
    chk("rst_tid", int'(fetch_tid), 0);
    chk("rst_pc", int'(fetch_pc), 0);
    chk("rst_imem_a", int'(imem_a), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_cmd_err", int'(cmd_err), 0);

    // Lone thread 2 from offset 5, wrapping 299 -> 200.
    for (int p = 5; p < 100; p++) push(2, p, 200 + p);
    push(2, 0, 200); push(2, 1, 201); push(2, 2, 202);
    fetch_ready = 1;
    start_valid = 1; start_tid = 2; start_pc = 5;
    tick();
    start_valid = 0;
    chk("t1_active", int'(active), 5'b00100);
    wait_beats(98, g);
    chk("t1_gaps", g, 0);
    halt_valid = 1; halt_tid = 2;
    tick();
    halt_valid = 0;
    chk("t1_halt_active", int'(active), 0);
    chk("t1_halt_valid", int'(fetch_valid), 0);
    repeat (4) tick();

    // Threads 0, 1, 4 interleave.
    fetch_ready = 0;
    start_valid = 1; start_tid = 0; start_pc = 0; tick();
    start_tid = 1; tick();
    start_tid = 4; tick();
    start_valid = 0; tick();
    chk("t2_active", int'(active), 5'b10011);
    chk("t2_pending_tid", int'(fetch_tid), 0);
    push(0, 0, 0); push(1, 0, 100); push(4, 0, 400);
    push(0, 1, 1); push(1, 1, 101); push(4, 1, 401); push(0, 2, 2);
    fetch_ready = 1;
    wait_beats(7, g);
    chk("t2_gaps", g, 0);
    @(posedge clk); #1;
    fetch_ready = 0;

    // Thread 1 beat held, then withdrawn by redirect.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_valid", int'(fetch_valid), 1);
      chk("t3_hold_tid", int'(fetch_tid), 1);
      chk("t3_hold_addr", int'(imem_a), 102);
    end
    redirect_valid = 1; redirect_tid = 1; redirect_pc = 40;
    tick();
    redirect_valid = 0;
    chk("t3_flush_tid", int'(fetch_tid), 4);
    chk("t3_flush_addr", int'(imem_a), 402);
    push(4, 2, 402); push(0, 3, 3); push(1, 40, 140);
    fetch_ready = 1;
    wait_beats(3, g);
    @(posedge clk); #1;
    fetch_ready = 0;

    // Thread 3 started, then halted and redirected in one cycle.
    tick();
    start_valid = 1; start_tid = 3; start_pc = 10;
    tick();
    start_valid = 0;
    chk("t4_start3", int'(active), 5'b11011);
    tick();
    halt_valid = 1; halt_tid = 3;
    redirect_valid = 1; redirect_tid = 3; redirect_pc = 10;
    tick();
    halt_valid = 0; redirect_valid = 0;
    chk("t4_active", int'(active), 5'b10011);
    chk("t4_pending_tid", int'(fetch_tid), 4);
    push(4, 3, 403); push(0, 4, 4); push(1, 41, 141);
    push(4, 4, 404); push(0, 5, 5); push(1, 42, 142);
    fetch_ready = 1;
    wait_beats(6, g);
    @(posedge clk); #1;
    fetch_ready = 0;

    // Invalid commands.
    tick();
    start_valid = 1; start_tid = 6; start_pc = 0;
    tick();
    start_valid = 0;
    chk("t5_err_tid", int'(cmd_err), 1);
    chk("t5_active_tid", int'(active), 5'b10011);
    tick();
    chk("t5_err_clear", int'(cmd_err), 0);
    start_valid = 1; start_tid = 0; start_pc = 100;
    tick();
    start_valid = 0;
    chk("t5_err_pc", int'(cmd_err), 1);
    chk("t5_active_pc", int'(active), 5'b10011);
    tick();
    chk("t5_err_clear2", int'(cmd_err), 0);

    // Stall thread 0; its pc resumes at 6 afterwards.
    thread_stall = 5'b00001;
    push(4, 5, 405); push(1, 43, 143); push(4, 6, 406); push(1, 44, 144);
    push(4, 7, 407); push(0, 6, 6); push(1, 45, 145);
    fetch_ready = 1;
    wait_beats(4, g);
    thread_stall = '0;
    tick();
    wait_beats(3, g);
    @(posedge clk); #1;
    fetch_ready = 0;

    // Reset mid-stream.
    tick();
    rst_n = 0;
    #1;
    chk("t6_rst_valid", int'(fetch_valid), 0);
    chk("t6_rst_active", int'(active), 0);
    chk("t6_rst_addr", int'(imem_a), 0);
    tick();
    rst_n = 1;
    fetch_ready = 1;
    repeat (8) tick();
    chk("t6_idle_valid", int'(fetch_valid), 0);

    // Top-of-window offset 99 for thread 3, then thread 0 joins.
    fetch_ready = 0;
    start_valid = 1; start_tid = 3; start_pc = 99;
    tick();
    start_valid = 0;
    tick();
    chk("t7_pending_addr", int'(imem_a), 399);
    start_valid = 1; start_tid = 0; start_pc = 7;
    tick();
    start_valid = 0;
    push(3, 99, 399); push(0, 7, 7); push(3, 0, 300); push(0, 8, 8); push(3, 1, 301);
    fetch_ready = 1;
    wait_beats(5, g);
    @(posedge clk); #1;
    fetch_ready = 0;
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
